// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM/WB pipeline slice.
// Holds the default datapath widths, the memory-wait FSM state type,
// the EX/MEM control bundle with its bubble value, and a small helper
// that tells whether a control bundle carries a data-memory operation.
package pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } waitState_t;

    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
    } emCtrl_t;

    localparam emCtrl_t BUBBLE_CTRL = '{regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0};

    function automatic logic isMemOp(input emCtrl_t ctrl);
        return ctrl.memRead | ctrl.memWrite;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait controller for the EX/MEM stage.
// Tracks whether the instruction sitting in EX/MEM is waiting on the data
// memory, produces the pipeline stall, and says when that instruction
// retires normally into MEM/WB.
// Optional feature: define MEMPIPE_TIMEOUT_EN to add a WAIT-cycle counter
// that gives up after TIMEOUT consecutive WAIT cycles, pulses memErr and
// lets the pipeline move on. Without it memErr is tied low and the
// controller waits for as long as the memory needs.
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memOp,
    input  logic memReady,
    output logic stall,
    output logic memErr,
    output logic retire
);

    waitState_t state;
    waitState_t nextState;
    logic       timeoutHit;

`ifdef MEMPIPE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] waitCount;

    // The limit is reached on the TIMEOUT-th WAIT cycle that still has no ready.
    always_comb begin
        timeoutHit = 1'b0;
        if ((state == WAIT) && memOp && !memReady && (waitCount == CNT_W'(TIMEOUT - 1))) begin
            timeoutHit = 1'b1;
        end
    end

    // WAIT-cycle counter: held at zero in IDLE so it starts fresh on every entry to WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCount <= '0;
        end else if (state == IDLE) begin
            waitCount <= '0;
        end else if (!timeoutHit) begin
            waitCount <= waitCount + CNT_W'(1);
        end
    end
`else
    // No give-up path: the stage waits on the memory indefinitely.
    always_comb begin
        timeoutHit = 1'b0;
    end
`endif

    // State register; reset abandons any wait in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus the stall/retire/error outputs seen by the pipeline registers.
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        memErr    = 1'b0;
        retire    = 1'b0;

        stall  = memOp & ~memReady & ~timeoutHit;
        memErr = timeoutHit;
        retire = ~memOp | memReady;

        unique case (state)
            IDLE: begin
                if (memOp && !memReady) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (memReady || timeoutHit || !memOp) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mem_pipeline_regs.sv
// EX/MEM and MEM/WB pipeline registers around the data-memory access.
// The EX/MEM register captures the EX instruction whenever the stage is not
// stalled (a flushed or invalid EX slot becomes a bubble). While EX/MEM
// holds a load or store, the memory request is driven straight from it, and
// the mem_wait_fsm sub-module decides whether to stall. A completed
// instruction moves into MEM/WB; a stalled cycle pushes a bubble instead.
// Optional feature: MEMPIPE_TIMEOUT_EN (see mem_wait_fsm) adds a wait
// timeout that raises mem_err and retires the stuck access as a bubble.
module mem_pipeline_regs
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [REG_W-1:0]  EM_RD,
    output logic              EM_RegWrite,
    output logic [REG_W-1:0]  MWB_RD,
    output logic              MWB_RegWrite,
    output logic [DATA_W-1:0] mwb_data,
    output logic              stall,
    output logic              mem_err
);

    emCtrl_t           exCtrl;
    logic              exTakes;

    emCtrl_t           emCtrl;
    logic [REG_W-1:0]  emRd;
    logic [DATA_W-1:0] emResult;
    logic [DATA_W-1:0] emStoreData;

    logic              mwbRegWrite;
    logic [REG_W-1:0]  mwbRd;
    logic [DATA_W-1:0] mwbData;

    logic              memOp;
    logic              stallInt;
    logic              memErrInt;
    logic              retire;

    assign exCtrl  = '{regWrite: ex_regwrite, memRead: ex_memread, memWrite: ex_memwrite};
    assign exTakes = ex_valid & ~flush;

    // EX/MEM register: frozen while stalled, otherwise the EX instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emCtrl      <= BUBBLE_CTRL;
            emRd        <= '0;
            emResult    <= '0;
            emStoreData <= '0;
        end else if (!stallInt) begin
            if (exTakes) begin
                emCtrl      <= exCtrl;
                emRd        <= ex_rd;
                emResult    <= ex_result;
                emStoreData <= ex_store_data;
            end else begin
                emCtrl      <= BUBBLE_CTRL;
                emRd        <= '0;
                emResult    <= '0;
                emStoreData <= '0;
            end
        end
    end

    assign memOp = isMemOp(emCtrl);

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) waitFsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .memOp    (memOp),
        .memReady (mem_ready),
        .stall    (stallInt),
        .memErr   (memErrInt),
        .retire   (retire)
    );

    // MEM/WB register: the retiring instruction, or a bubble when nothing retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mwbRegWrite <= 1'b0;
            mwbRd       <= '0;
            mwbData     <= '0;
        end else if (retire) begin
            mwbRegWrite <= emCtrl.regWrite & ~emCtrl.memWrite;
            mwbRd       <= emRd;
            mwbData     <= emCtrl.memRead ? mem_rdata : emResult;
        end else begin
            mwbRegWrite <= 1'b0;
            mwbRd       <= '0;
            mwbData     <= '0;
        end
    end

    // The memory request comes straight from EX/MEM, so it cannot change while the stage waits.
    always_comb begin
        mem_req   = memOp;
        mem_we    = emCtrl.memWrite;
        mem_addr  = emResult;
        mem_wdata = emStoreData;
    end

    assign EM_RD        = emRd;
    assign EM_RegWrite  = emCtrl.regWrite;
    assign MWB_RD       = mwbRd;
    assign MWB_RegWrite = mwbRegWrite;
    assign mwb_data     = mwbData;
    assign stall        = stallInt;
    assign mem_err      = memErrInt;

endmodule

// File: tb/tb_mem_pipeline_regs.sv
// Self-checking bench for mem_pipeline_regs.
// A behavioural model (one slot per pipeline register plus a count of how
// long the current memory access has been pending) predicts every output
// each cycle. Directed cases are followed by randomized traffic.
// Build with MEMPIPE_TIMEOUT_EN defined to exercise the timeout path.
module tb_mem_pipeline_regs;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_result, ex_store_data;
    logic          flush;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [RW-1:0] EM_RD;
    logic          EM_RegWrite;
    logic [RW-1:0] MWB_RD;
    logic          MWB_RegWrite;
    logic [DW-1:0] mwb_data;
    logic          stall, mem_err;

    mem_pipeline_regs #(
        .DATA_W  (DW),
        .REG_W   (RW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .ex_memwrite   (ex_memwrite),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .EM_RD         (EM_RD),
        .EM_RegWrite   (EM_RegWrite),
        .MWB_RD        (MWB_RD),
        .MWB_RegWrite  (MWB_RegWrite),
        .mwb_data      (mwb_data),
        .stall         (stall),
        .mem_err       (mem_err)
    );

    // Free-running clock, first rising edge at 5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic          mr;
        logic          mw;
        logic [RW-1:0] rd;
        logic [DW-1:0] res;
        logic [DW-1:0] sd;
    } instr_t;

    instr_t        mEm;
    logic          mMwbRw;
    logic [RW-1:0] mMwbRd;
    logic [DW-1:0] mMwbData;
    int            pend;

    int errorCount = 0;
    int checkCount = 0;
    int stallSeen  = 0;
    int errSeen    = 0;
    int errIndex   = -1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        mEm      = '0;
        mMwbRw   = 1'b0;
        mMwbRd   = '0;
        mMwbData = '0;
        pend     = 0;
    endtask

    function automatic logic modelTimeout();
        logic hit;
        hit = 1'b0;
`ifdef MEMPIPE_TIMEOUT_EN
        hit = (mEm.mr || mEm.mw) && !mem_ready && (pend == TO);
`endif
        return hit;
    endfunction

    task automatic checkAllOutputs(input string phase);
        logic memOp, toHit, expStall;
        memOp    = mEm.mr | mEm.mw;
        toHit    = modelTimeout();
        expStall = memOp && !mem_ready && !toHit;
        checkOutput({phase, ":mem_req"},      32'(mem_req),      32'(memOp));
        checkOutput({phase, ":mem_we"},       32'(mem_we),       32'(mEm.mw));
        checkOutput({phase, ":mem_addr"},     32'(mem_addr),     32'(mEm.res));
        checkOutput({phase, ":mem_wdata"},    32'(mem_wdata),    32'(mEm.sd));
        checkOutput({phase, ":stall"},        32'(stall),        32'(expStall));
        checkOutput({phase, ":mem_err"},      32'(mem_err),      32'(toHit));
        checkOutput({phase, ":EM_RD"},        32'(EM_RD),        32'(mEm.rd));
        checkOutput({phase, ":EM_RegWrite"},  32'(EM_RegWrite),  32'(mEm.rw));
        checkOutput({phase, ":MWB_RD"},       32'(MWB_RD),       32'(mMwbRd));
        checkOutput({phase, ":MWB_RegWrite"}, 32'(MWB_RegWrite), 32'(mMwbRw));
        checkOutput({phase, ":mwb_data"},     32'(mwb_data),     32'(mMwbData));
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic updateModel();
        logic memOp, toHit, stalled, done;
        memOp   = mEm.mr | mEm.mw;
        toHit   = modelTimeout();
        stalled = memOp && !mem_ready && !toHit;
        done    = !memOp || mem_ready;
        if (done) begin
            mMwbRw   = mEm.rw && !mEm.mw;
            mMwbRd   = mEm.rd;
            mMwbData = mEm.mr ? mem_rdata : mEm.res;
        end else begin
            mMwbRw   = 1'b0;
            mMwbRd   = '0;
            mMwbData = '0;
        end
        if (stalled) begin
            pend++;
        end else begin
            pend = 0;
            if (ex_valid && !flush) begin
                mEm = '{rw: ex_regwrite, mr: ex_memread, mw: ex_memwrite,
                        rd: ex_rd, res: ex_result, sd: ex_store_data};
            end else begin
                mEm = '0;
            end
        end
    endtask

    // One cycle: drive at the falling edge, check just after, then take the rising edge.
    task automatic applyStimulus(input logic valid, input logic rw, input logic mr, input logic mw,
                                 input logic [RW-1:0] rd, input logic [DW-1:0] res,
                                 input logic [DW-1:0] sd, input logic fl, input logic ready,
                                 input logic [DW-1:0] rdata, input string phase);
        @(negedge clk);
        ex_valid      = valid;
        ex_regwrite   = rw;
        ex_memread    = mr;
        ex_memwrite   = mw;
        ex_rd         = rd;
        ex_result     = res;
        ex_store_data = sd;
        flush         = fl;
        mem_ready     = ready;
        mem_rdata     = rdata;
        #1;
        checkAllOutputs(phase);
        if (stall) stallSeen++;
        if (mem_err) errSeen++;
        @(posedge clk);
        updateModel();
    endtask

    task automatic bubble(input logic ready, input logic [DW-1:0] rdata, input string phase);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, ready, rdata, phase);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
        ex_rd = '0; ex_result = '0; ex_store_data = '0; flush = 0;
        mem_ready = 1'b0; mem_rdata = '0;
        clearModel();

        // Reset state, then release between edges.
        #3;
        checkAllOutputs("reset");
        #4;
        rst_n = 1'b1;

        // ALU pass-through, accepted on the first edge after reset release.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 16'h00AB, 16'h0000, 1'b0, 1'b1, 16'h0000, "alu");
        #1;
        checkOutput("alu:EM_RD edge1", 32'(EM_RD), 32'd12);
        checkOutput("alu:EM_RegWrite edge1", 32'(EM_RegWrite), 32'd1);
        bubble(1'b1, 16'h0000, "alu2");
        #1;
        checkOutput("alu:MWB_RD edge2", 32'(MWB_RD), 32'd12);
        checkOutput("alu:mwb_data edge2", 32'(mwb_data), 32'h00AB);

        // Load held off by the memory for three cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'h0000, "ld");
        stallSeen = 0;
        for (int i = 0; i < 3; i++) begin
            bubble(1'b0, 16'hDEAD, "ldwait");
            #1;
            checkOutput("ldwait:MWB_RegWrite", 32'(MWB_RegWrite), 32'd0);
        end
        bubble(1'b1, 16'h1234, "lddone");
        checkOutput("ld:stall cycles", 32'(stallSeen), 32'd3);
        #1;
        checkOutput("ld:MWB_RD", 32'(MWB_RD), 32'd13);
        checkOutput("ld:mwb_data", 32'(mwb_data), 32'h1234);
        checkOutput("ld:MWB_RegWrite", 32'(MWB_RegWrite), 32'd1);

        // Store with immediate ready: no stall, no register write.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0080, 16'h5555, 1'b0, 1'b1, 16'h0000, "st");
        stallSeen = 0;
        #1;
        checkOutput("st:mem_we", 32'(mem_we), 32'd1);
        checkOutput("st:mem_wdata", 32'(mem_wdata), 32'h5555);
        bubble(1'b1, 16'h0000, "st2");
        checkOutput("st:stall cycles", 32'(stallSeen), 32'd0);
        #1;
        checkOutput("st:MWB_RegWrite", 32'(MWB_RegWrite), 32'd0);

        // Flush turns the EX instruction into a bubble.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 16'h0F0F, 16'h0000, 1'b1, 1'b1, 16'h0000, "flush");
        #1;
        checkOutput("flush:EM_RD", 32'(EM_RD), 32'd0);
        checkOutput("flush:EM_RegWrite", 32'(EM_RegWrite), 32'd0);

        // Flush during a stall leaves EX/MEM untouched.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0000, "ld7");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 16'h0000, "flushstall");
        #1;
        checkOutput("flushstall:EM_RD", 32'(EM_RD), 32'd7);
        checkOutput("flushstall:EM_RegWrite", 32'(EM_RegWrite), 32'd1);
        bubble(1'b1, 16'h7777, "ld7done");
        bubble(1'b1, 16'h0000, "idle");

        // Reset asserted in the middle of a wait.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 16'h0050, 16'h0000, 1'b0, 1'b1, 16'h0000, "ld5");
        bubble(1'b0, 16'h0000, "ld5wait");
        bubble(1'b0, 16'h0000, "ld5wait");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("rstwait:mem_req", 32'(mem_req), 32'd0);
        checkOutput("rstwait:stall", 32'(stall), 32'd0);
        checkAllOutputs("rstwait");
        @(posedge clk);
        #1;
        checkAllOutputs("rsthold");
        @(negedge clk);
        rst_n = 1'b1;
        bubble(1'b1, 16'hAAAA, "postrst");
        bubble(1'b1, 16'hAAAA, "postrst");
        #1;
        checkOutput("postrst:MWB_RegWrite", 32'(MWB_RegWrite), 32'd0);

        // Memory never answers.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 16'h0090, 16'h0000, 1'b0, 1'b1, 16'h0000, "ld9");
        stallSeen = 0;
        errSeen   = 0;
`ifdef MEMPIPE_TIMEOUT_EN
        errIndex = -1;
        for (int i = 0; i < 8; i++) begin
            bubble(1'b0, 16'h0000, "tmo");
            if (errSeen == 1 && errIndex < 0) errIndex = i;
            #1;
            if (i == 4) checkOutput("tmo:MWB_RegWrite", 32'(MWB_RegWrite), 32'd0);
        end
        checkOutput("tmo:mem_err pulses", 32'(errSeen), 32'd1);
        checkOutput("tmo:mem_err cycle", 32'(errIndex), 32'd4);
        checkOutput("tmo:stall cycles", 32'(stallSeen), 32'd4);
`else
        for (int i = 0; i < 20; i++) begin
            bubble(1'b0, 16'h0000, "hang");
        end
        checkOutput("hang:stall cycles", 32'(stallSeen), 32'd20);
        checkOutput("hang:mem_err pulses", 32'(errSeen), 32'd0);
        bubble(1'b1, 16'h9999, "hangdone");
`endif
        bubble(1'b1, 16'h0000, "idle");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int op;
            logic rw, mr, mw;
            op = int'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            mr = (op == 2);
            mw = (op == 3);
            if (op == 2) rw = 1'b1;
            applyStimulus(($urandom_range(0, 9) != 0), rw, mr, mw,
                          RW'($urandom), DW'($urandom), DW'($urandom),
                          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                          DW'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_pipeline_regs.md
MEM_PIPELINE_REGS -- requirements
Module: mem_pipeline_regs

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter REG_W, default 4, register-index width.
REQ-003 SHALL have parameter TIMEOUT, default 15, wait-cycle limit (used only under MEMPIPE_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports ex_valid, ex_regwrite, ex_memread, ex_memwrite  in  1 each  EX-stage control.
REQ-007 SHALL have port ex_rd  in  REG_W  EX destination register.
REQ-008 SHALL have ports ex_result, ex_store_data  in  DATA_W  ALU result/address, store data.
REQ-009 SHALL have port flush  in  1  replace the incoming EX instruction with a bubble.
REQ-010 SHALL have ports mem_req, mem_we  out  1; mem_addr, mem_wdata  out  DATA_W  data-memory request.
REQ-011 SHALL have ports mem_rdata  in  DATA_W; mem_ready  in  1  data-memory response.
REQ-012 SHALL have ports EM_RD  out  REG_W; EM_RegWrite  out  1  EX/MEM state to the forwarding unit.
REQ-013 SHALL have ports MWB_RD  out  REG_W; MWB_RegWrite  out  1; mwb_data  out  DATA_W  MEM/WB state.
REQ-014 SHALL have ports stall  out  1; mem_err  out  1.

Function
REQ-015 SHALL load the EM register from ex_* at each clk edge where stall=0.
- ex_valid=0 or flush=1 loads a bubble: all EM controls 0, EM_RD 0.
REQ-016 SHALL hold the EM register unchanged while stall=1; flush is ignored while stall=1.
REQ-017 SHALL implement FSM states IDLE and WAIT.
REQ-018 SHALL drive mem_req=1 combinationally whenever EM holds memread or memwrite and the FSM is in IDLE or WAIT.
- mem_we=EM memwrite; mem_addr=EM result; mem_wdata=EM store data.
- All four outputs SHALL be stable throughout WAIT.
REQ-019 SHALL drive stall = EM memory op AND NOT mem_ready, combinationally.
REQ-020 SHALL perform the following FSM transitions.
- IDLE->WAIT on a memory op with mem_ready=0.
- WAIT->IDLE on mem_ready=1.
- A memory op with mem_ready=1 in IDLE completes in the same cycle and the FSM stays in IDLE.
REQ-021 SHALL, on an EM instruction completing (non-memory op, or memory op with mem_ready=1), load MWB with the following values.
- MWB_RD=EM_RD.
- MWB_RegWrite=EM regwrite AND NOT EM memwrite.
- mwb_data=mem_rdata for a load, else EM result.
REQ-022 SHALL load a bubble into MWB (MWB_RegWrite=0, MWB_RD=0, mwb_data=0) on every stalled cycle.
REQ-023 SHALL give a non-memory instruction a latency of 1 edge to EM and 2 edges to MWB; each WAIT cycle adds 1 edge.
REQ-024 SHALL pass EM_RD/MWB_RD=0 through unchanged; register-0 policy belongs to the register file.
REQ-025 SHALL allow back-to-back memory ops; the next op enters EM on the completion edge.

Reset
REQ-026 SHALL, while rst_n=0, clear every register immediately and force the FSM to IDLE.
- All outputs SHALL be 0, including mem_req, stall and mem_err.
REQ-027 SHALL drop mem_req and abandon any WAIT in progress on reset assertion; no MWB write occurs for that instruction.
REQ-028 SHALL accept the first instruction at the first clk edge after rst_n rises.

Configuration
REQ-029 SHALL compile, under macro MEMPIPE_TIMEOUT_EN, a WAIT-cycle counter.
- The counter clears on entry to WAIT.
- On TIMEOUT consecutive WAIT cycles without mem_ready, mem_err SHALL pulse 1 cycle and stall SHALL deassert.
- The instruction SHALL retire into MWB as a bubble and the FSM SHALL return to IDLE.
REQ-030 SHALL, without MEMPIPE_TIMEOUT_EN, tie mem_err to 0 and wait indefinitely in WAIT.

Structure
REQ-031 SHALL take DATA_W/REG_W defaults, the FSM state enum and the bubble constant from shared package pipe_pkg.
REQ-032 SHALL place the FSM, stall and timeout logic in sub-module mem_wait_fsm; the EM/MWB registers stay in the top.

Verification
REQ-033 SHALL cover the following ALU pass-through case.
- Stimulus: ex_rd=12, ex_regwrite=1, ex_result=16'h00AB, mem_ready=1.
- Response: EM_RD=12/EM_RegWrite=1 after edge 1; MWB_RD=12, mwb_data=16'h00AB after edge 2.
REQ-034 SHALL cover the following load with wait case.
- Stimulus: ex_memread=1, ex_rd=13, ex_result=16'h0040, mem_ready low 3 cycles then high, mem_rdata=16'h1234.
- Response: stall=1 for exactly 3 cycles, mem_addr=16'h0040 stable, then MWB_RD=13, mwb_data=16'h1234.
- Response: MWB_RegWrite=0 during the stall.
REQ-035 SHALL cover the following store case.
- Stimulus: ex_memwrite=1, ex_regwrite=1, ex_store_data=16'h5555, mem_ready=1.
- Response: mem_we=1, mem_wdata=16'h5555, no stall, MWB_RegWrite=0.
REQ-036 SHALL cover the following flush case.
- Stimulus: flush=1 with ex_rd=15, ex_regwrite=1.
- Response: EM_RegWrite=0, EM_RD=0; flush asserted during a stall leaves EM unchanged.
REQ-037 SHALL cover the following reset-in-WAIT case.
- Stimulus: rst_n=0 during WAIT.
- Response: mem_req=0 and stall=0 immediately; all outputs 0; no MWB write after release.
REQ-038 SHALL cover the following timeout case with MEMPIPE_TIMEOUT_EN and TIMEOUT=4.
- Stimulus: mem_ready held 0.
- Response: mem_err=1 for one cycle on the 4th WAIT cycle, FSM IDLE, MWB_RegWrite=0.
